// File: rtl/sum4_pkg.sv
// Shared types and widths for the sum4mult arbiter slice.
// The tag type is sized for the largest supported requester count.
package sum4_pkg;

  localparam int VEC_W    = 44;
  localparam int FP_W     = 11;
  localparam int LANES    = 4;
  localparam int LANE_W   = VEC_W / LANES;
  localparam int NREQ_MAX = 8;
  localparam int TAG_W    = $clog2(NREQ_MAX);

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [FP_W-1:0]  fp_t;

endpackage

// File: rtl/sum4_tag_fifo.sv
// Owner-tag FIFO: one entry per in-flight sum4mult op, popped in issue order.
// Occupancy is tracked by a count so full and empty never depend on pointer equality.
module sum4_tag_fifo
  import sum4_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  tag_t                       push_tag,
  input  logic                       pop,
  output tag_t                       head_tag,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;
  tag_t             mem_q [DEPTH];

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign head_tag = mem_q[rd_ptr_q];

  // A push while full is legal only when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_tag;
    end
  end

endmodule

// File: rtl/sum4_rr_arbiter.sv
// Round-robin front end for a single sum4mult datapath: grants one requester per cycle,
// registers its operands into the datapath and steers each result back to its owner.
module sum4_rr_arbiter #(
  parameter int NREQ         = 4,
  parameter int MAX_INFLIGHT = 8,
  parameter int VEC_W        = 44,
  parameter int FP_W         = 11
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NREQ-1:0]                   req_valid,
  output logic [NREQ-1:0]                   req_ready,
  input  logic [NREQ*VEC_W-1:0]             req_A,
  input  logic [NREQ*VEC_W-1:0]             req_B,
  output logic                              dp_pushin,
  output logic [VEC_W-1:0]                  dp_A,
  output logic [VEC_W-1:0]                  dp_B,
  input  logic                              dp_pushout,
  input  logic [FP_W-1:0]                   dp_Z,
  output logic [NREQ-1:0]                   resp_valid,
  output logic [FP_W-1:0]                   resp_Z,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              err_orphan
);

  import sum4_pkg::*;

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(MAX_INFLIGHT+1);

  logic [VEC_W-1:0] a_arr [NREQ];
  logic [VEC_W-1:0] b_arr [NREQ];

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] grant_idx, scan_idx;
  logic             grant_found, can_issue, handshake;

  logic             dp_pushin_q, dp_pushin_d;
  logic [VEC_W-1:0] dp_a_q, dp_a_d;
  logic [VEC_W-1:0] dp_b_q, dp_b_d;

  logic [NREQ-1:0]  resp_valid_q, resp_valid_d;
  logic [FP_W-1:0]  resp_z_q, resp_z_d;
  logic             err_orphan_q, err_orphan_d;

  logic             fifo_pop, fifo_empty, fifo_full;
  logic [CNT_W-1:0] fifo_count;
  tag_t             head_tag;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_A[i*VEC_W +: VEC_W];
    assign b_arr[i] = req_B[i*VEC_W +: VEC_W];
  end

  // Scan from the farthest offset back to rr_ptr so the last hit is the nearest valid requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int off = NREQ-1; off >= 0; off--) begin
      scan_idx = PTR_W'((int'(rr_ptr_q) + off) % NREQ);
      if (req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // A pushout frees a slot in the same cycle, so a full FIFO can still accept a grant.
  assign can_issue = ~fifo_full | dp_pushout;
  assign handshake = grant_found & can_issue & ~reset;
  assign req_ready = handshake ? (NREQ'(1) << grant_idx) : '0;

  assign fifo_pop  = dp_pushout & ~fifo_empty;

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    dp_pushin_d  = handshake;
    dp_a_d       = dp_a_q;
    dp_b_d       = dp_b_q;
    resp_valid_d = '0;
    resp_z_d     = resp_z_q;
    err_orphan_d = err_orphan_q | (dp_pushout & fifo_empty);
    if (handshake) begin
      rr_ptr_d = (grant_idx == PTR_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;
      dp_a_d   = a_arr[grant_idx];
      dp_b_d   = b_arr[grant_idx];
    end
    if (fifo_pop) begin
      resp_valid_d = NREQ'(1) << head_tag;
      resp_z_d     = dp_Z;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      dp_pushin_q  <= 1'b0;
      dp_a_q       <= '0;
      dp_b_q       <= '0;
      resp_valid_q <= '0;
      resp_z_q     <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      dp_pushin_q  <= dp_pushin_d;
      dp_a_q       <= dp_a_d;
      dp_b_q       <= dp_b_d;
      resp_valid_q <= resp_valid_d;
      resp_z_q     <= resp_z_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  sum4_tag_fifo #(
    .DEPTH(MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (handshake),
    .push_tag (TAG_W'(grant_idx)),
    .pop      (fifo_pop),
    .head_tag (head_tag),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign dp_pushin  = dp_pushin_q;
  assign dp_A       = dp_a_q;
  assign dp_B       = dp_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_Z     = resp_z_q;
  assign inflight   = fifo_count;
  assign err_orphan = err_orphan_q;

endmodule
